// File: rtl/uart_rx_pkg.sv
// Shared types and default sizing for the iceMCU UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        FLUSH
    } rx_state_t;

    localparam int CLK_DIV_DEFAULT    = 35;
    localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is always on pop_data.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    // Gate the head while empty so the output is a clean zero after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with centre sampling, FWFT receive FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       overrun
);

    localparam int            TW       = $clog2(CLK_DIV);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLK_DIV / 2);
    localparam logic [TW-1:0] FULL_BIT = TW'(CLK_DIV - 1);

    logic          sync1_reg;
    logic          rxs_reg;
    rx_state_t     state_reg,   state_next;
    logic [TW-1:0] timer_reg,   timer_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg,   shift_next;
    logic          frame_err_reg;
    logic          overrun_reg;
    logic          push;
    logic          frame_set;
    logic          overrun_set;
    logic          fifo_full;
    logic          fifo_empty;
    logic          expired;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_reg, par_bad_next;
    logic          parity_set;
    logic          parity_err_reg;
`endif

    assign expired = (timer_reg == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg   <= 1'b1;
            rxs_reg     <= 1'b1;
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            sync1_reg   <= rx;
            rxs_reg     <= sync1_reg;
            state_reg   <= state_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        timer_next   = expired ? timer_reg : timer_reg - TW'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        push         = 1'b0;
        frame_set    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
        parity_set   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!rxs_reg) begin
                    timer_next = HALF_BIT;
                    state_next = START;
                end
            end
            START: begin
                if (expired) begin
                    if (!rxs_reg) begin
                        timer_next   = FULL_BIT;
                        bit_idx_next = '0;
                        state_next   = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DATA: begin
                if (expired) begin
                    shift_next   = {rxs_reg, shift_reg[7:1]};
                    timer_next   = FULL_BIT;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expired) begin
                    timer_next   = FULL_BIT;
                    par_bad_next = (^shift_reg) ^ rxs_reg;
                    parity_set   = (^shift_reg) ^ rxs_reg;
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (expired) begin
                    if (rxs_reg) begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_reg;
`else
                        push = 1'b1;
`endif
                        state_next = IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // A held-low line (break) must produce only one framing error.
                if (rxs_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // When full, a same-cycle rd frees the slot, so only a read-less push is lost.
    assign overrun_set = push && fifo_full && !rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= frame_set   | (frame_err_reg & ~clr_err);
            overrun_reg   <= overrun_set | (overrun_reg   & ~clr_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bad_reg    <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            par_bad_reg    <= par_bad_next;
            parity_err_reg <= parity_set | (parity_err_reg & ~clr_err);
        end
    end

    assign parity_err = parity_err_reg;
`endif

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (reset),
        .push      (push),
        .push_data (shift_reg),
        .pop       (rd),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rx_valid  = !fifo_empty;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, scoreboard queue and corner sequences.
module tb_uart_rx_fifo;
    import uart_rx_pkg::*;

    localparam int CLK_DIV = CLK_DIV_DEFAULT;
    localparam int DEPTH   = FIFO_DEPTH_DEFAULT;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Stop bit is sampled mid-bit; allow sync flops plus a decision cycle.
    localparam int LAT_MIN = (FRAME_BITS - 1) * CLK_DIV;
    localparam int LAT_MAX = ((2 * FRAME_BITS - 1) * CLK_DIV) / 2 + 4;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rd;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip;
`endif

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    uart_rx_fifo #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd         (rd),
        .clr_err    (clr_err),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
            $display("check %s: got 0x%0h ok", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input int hold);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_b);
        repeat (hold) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard model: a byte is kept only while the FIFO has room.
    task automatic expect_byte(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        int n = 0;
        while (!rx_valid && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) begin
            check({name, "_timeout"}, 32'(rx_valid), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check({name, "_unexpected"}, 32'(rx_valid), 32'd0);
            return;
        end
        exp = exp_q.pop_front();
        check(name, 32'(rx_data), 32'(exp));
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        int lat;
        int err_cycles;

        vecs[0] = '{8'hA5, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1};
        vecs[4] = '{8'h55, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b0, 1'b1};
        vecs[6] = '{8'h7E, 1'b1, 1'b0};

        reset   = 1'b1;
        rx      = 1'b1;
        rd      = 1'b0;
        clr_err = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_flip = 1'b0;
`endif
        repeat (4) @(negedge clk);
        check("reset_rx_valid",  32'(rx_valid),  32'd0);
        check("reset_rx_data",   32'(rx_data),   32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun",   32'(overrun),   32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // First byte with a latency window measured from the start edge.
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                while (!rx_valid && lat < LAT_MAX + 50) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("latency_in_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
        expect_byte(8'hA5);
        pop_check("first_byte");
        check("empty_after_rd", 32'(rx_valid), 32'd0);

        // Start-bit glitch shorter than half a bit.
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLK_DIV) @(negedge clk);
        check("glitch_rx_valid",  32'(rx_valid),  32'd0);
        check("glitch_frame_err", 32'(frame_err), 32'd0);
        check("glitch_overrun",   32'(overrun),   32'd0);

        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].data, vecs[v].stop_bit, 0);
            check($sformatf("vec%0d_frame_err", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
            if (vecs[v].stop_bit) begin
                expect_byte(vecs[v].data);
                pop_check($sformatf("vec%0d_data", v));
            end else begin
                check($sformatf("vec%0d_no_byte", v), 32'(rx_valid), 32'd0);
                pulse_clr();
                check($sformatf("vec%0d_err_cleared", v), 32'(frame_err), 32'd0);
            end
        end

        // Framing error followed by a break, then a good byte.
        send_frame(8'h3C, 1'b0, 50);
        check("break_frame_err", 32'(frame_err), 32'd1);
        check("break_no_byte",   32'(rx_valid),  32'd0);
        send_frame(8'h11, 1'b1, 0);
        expect_byte(8'h11);
        pop_check("after_break_data");
        check("frame_err_sticky", 32'(frame_err), 32'd1);
        pulse_clr();
        check("frame_err_cleared", 32'(frame_err), 32'd0);

        // clr_err held across a set event: set wins for exactly one cycle.
        err_cycles = 0;
        clr_err = 1'b1;
        fork
            send_frame(8'h66, 1'b0, 0);
            begin
                repeat (FRAME_BITS * CLK_DIV + 8) begin
                    @(negedge clk);
                    if (frame_err) err_cycles++;
                end
            end
        join
        clr_err = 1'b0;
        check("set_wins_one_cycle", 32'(err_cycles), 32'd1);
        check("set_wins_then_clear", 32'(frame_err), 32'd0);

        // Overrun: one byte more than the FIFO holds, no reads.
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send_frame(8'(i), 1'b1, 0);
            expect_byte(8'(i));
        end
        check("overrun_set", 32'(overrun), 32'd1);
        for (int i = 1; i <= DEPTH; i++) pop_check($sformatf("overrun_read%0d", i));
        check("overrun_drained", 32'(rx_valid), 32'd0);
        pulse_clr();
        check("overrun_cleared", 32'(overrun), 32'd0);

        // Reset in the middle of a frame with bytes queued and a flag set.
        send_frame(8'h21, 1'b1, 0);
        expect_byte(8'h21);
        send_frame(8'h42, 1'b1, 0);
        expect_byte(8'h42);
        send_frame(8'h99, 1'b0, 0);
        check("pre_reset_frame_err", 32'(frame_err), 32'd1);
        check("pre_reset_rx_valid",  32'(rx_valid),  32'd1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_rx_valid",  32'(rx_valid),  32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_overrun",   32'(overrun),   32'd0);
        check("midreset_rx_data",   32'(rx_data),   32'd0);
        exp_q.delete();
        rx = 1'b1;
        repeat (2 * FRAME_BITS * CLK_DIV) @(negedge clk);
        send_frame(8'h5A, 1'b1, 0);
        expect_byte(8'h5A);
        pop_check("post_reset_data");
        check("post_reset_empty", 32'(rx_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h03, 1'b1, 0);
        check("parity_err_set",  32'(parity_err), 32'd1);
        check("parity_no_byte",  32'(rx_valid),   32'd0);
        par_flip = 1'b0;
        send_frame(8'h03, 1'b1, 0);
        expect_byte(8'h03);
        pop_check("parity_good_data");
        pulse_clr();
        check("parity_err_cleared", 32'(parity_err), 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
